nexys_starship_break_gen: RTL
=============================

Name: nexys_starship_break_gen

Overview:
Event producer for the Nexys Starship repair subsystem. It generates the random break requests and repair combos consumed by the four part-repair state machines (left, right, top, bottom). A 16-bit LFSR runs on the slow game tick. The block picks a part, sends a break request with a non-zero 4-bit combo, holds the request until the part reports broken, then applies a per-part cooldown. Break probability rises with a level counter as play continues.

Parameters:
SEED, 16'hACE1, LFSR load value in IDLE; must be non-zero.
COOLDOWN, 8'd4, ticks a part is ineligible after its repair completes.
ACK_TIMEOUT, 8'd8, ISSUE ticks without acknowledge before the request is dropped.
LEVEL_PERIOD, 8'd30, active ticks per level increment.
MAX_BROKEN, 3'd2, maximum number of parts broken at once; no new issue at or above this.

Ports:
timer_clk  in  1  game tick clock (slow)
Reset  in  1  asynchronous, active-high
play_flag  in  1  game start level
gameover_ctrl  in  1  game over; returns block to IDLE
broken  in  4  per-part broken status {bottom,top,right,left} from repair SMs (acknowledge)
break_req  out  4  one-hot break request, held until acknowledged or timed out
random_hex  out  4  repair combo for the active request; never 0 when issued
level  out  2  current difficulty level 0..3
missed  out  1  one-tick pulse when a request times out

Behaviour:
- Reset is asynchronous and active-high; the clock is timer_clk. Everything except Reset is synchronous to timer_clk rising edges.
- Reset values: state=IDLE, lfsr=SEED, break_req=0, random_hex=0, level=0, missed=0, all cooldown counters=0, level tick counter=0.
- LFSR is 16-bit Galois: next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0). It is held at SEED in IDLE and shifts on every ARMED and ISSUE edge.
- Per-tick fields, decoded from the current (pre-shift) lfsr:
  - ch = lfsr[1:0]
  - roll = lfsr[7:4]
  - hexraw = lfsr[11:8]
- Threshold by level: 0->2, 1->5, 2->8, 3->11.
- fire = (roll <= thr) && !broken[ch] && cool[ch]==0 && popcount(broken) < MAX_BROKEN.
- IDLE:
  - outputs cleared; level=0, level counter=0, cooldowns=0, lfsr=SEED.
  - play_flag=1 -> ARMED next edge. The lfsr is not shifted on this edge.
- ARMED:
  - if fire: on the same edge set break_req <= 1<<ch, random_hex <= (hexraw==0 ? 4'hF : hexraw), latch ch, clear the ack-timer, -> ISSUE.
  - otherwise stay in ARMED.
- ISSUE:
  - break_req and random_hex are held stable.
  - if broken[ch]=1: break_req <= 0, cool[ch] <= COOLDOWN, -> ARMED. No new issue can fire on this edge.
  - else the ack-timer increments. When it reaches ACK_TIMEOUT-1 without acknowledge: break_req <= 0, missed <= 1 for one tick, -> ARMED. cool[ch] is not loaded in this case.
  - if broken[ch] rises on the timeout edge, acknowledge wins (no missed pulse).
- Cooldown: each cool[i] decrements by 1 per edge only while cool[i]!=0, broken[i]=0, and state is not IDLE. It saturates at 0. The buffer therefore counts from the moment the repair completes.
- Level: the tick counter increments on every ARMED/ISSUE edge. At LEVEL_PERIOD-1 it wraps to 0 and level increments, saturating at 3.
- random_hex keeps its last value after the request clears; repair SMs latch it on request.
- gameover_ctrl=1 in any non-IDLE state -> IDLE on the next edge with full IDLE clearing, including a mid-ISSUE abort. gameover_ctrl has priority over acknowledge and timeout.
- play_flag is ignored outside IDLE.
- Unreachable state encodings -> IDLE.

Test Plan:
1. Reset -> break_req=0, random_hex=0, level=0, missed=0; assert play_flag with gameover_ctrl=0 -> state ARMED after 1 edge.
2. SEED=16'h0003, broken=0: first ARMED edge -> break_req=4'b1000 and random_hex=4'hF (zero combo remapped); break_req stays 4'b1000 and random_hex stays F until broken[3]=1, then break_req=0 on the next edge.
3. Hold broken=0 after an issue, ACK_TIMEOUT=8 -> break_req drops and missed pulses high for exactly 1 tick, 8 edges after issue; with broken rising on the timeout edge -> no missed pulse.
4. Acknowledge on part 2, COOLDOWN=4, keep broken[2]=1 for 10 ticks then release -> no break_req[2] during the broken period or the 4 ticks after release, even with SEED forcing ch=2.
5. LEVEL_PERIOD=4 -> level = 1, 2, 3 at 4, 8, 12 active ticks; level stays 3 at tick 40. With broken=4'b0011 and MAX_BROKEN=2 -> no break_req for 50 ticks.
6. gameover_ctrl pulsed mid-ISSUE -> next edge break_req=0, level=0, state IDLE; a new play_flag reproduces the identical request sequence from SEED.

Source files
------------

// File: rtl/nexys_starship_break_gen.sv
// Break-request generator for the Nexys Starship repair game: an LFSR on the game tick
// picks a part and combo, holds the request until acknowledged or timed out, then cools the part down.
module nexys_starship_break_gen #(
    parameter logic [15:0] SEED         = 16'hACE1,
    parameter logic [7:0]  COOLDOWN     = 8'd4,
    parameter logic [7:0]  ACK_TIMEOUT  = 8'd8,
    parameter logic [7:0]  LEVEL_PERIOD = 8'd30,
    parameter logic [2:0]  MAX_BROKEN   = 3'd2
) (
    input  logic       timer_clk,
    input  logic       Reset,
    input  logic       play_flag,
    input  logic       gameover_ctrl,
    input  logic [3:0] broken,
    output logic [3:0] break_req,
    output logic [3:0] random_hex,
    output logic [1:0] level,
    output logic       missed
);

    localparam int unsigned N_PARTS = 4;
    localparam logic [15:0] TAPS     = 16'hB400;
    localparam logic [7:0]  LVL_LAST = LEVEL_PERIOD - 8'd1;
    localparam logic [7:0]  ACK_LAST = ACK_TIMEOUT - 8'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [15:0]                    lfsr_q, lfsr_d;
    logic [3:0]                     break_req_q, break_req_d;
    logic [3:0]                     random_hex_q, random_hex_d;
    logic [1:0]                     level_q, level_d;
    logic                           missed_q, missed_d;
    logic [N_PARTS-1:0][7:0]        cool_q, cool_d;
    logic [7:0]                     tick_cnt_q, tick_cnt_d;
    logic [7:0]                     ack_cnt_q, ack_cnt_d;
    logic [1:0]                     ch_q, ch_d;

    logic [1:0]  ch;
    logic [3:0]  roll;
    logic [3:0]  hexraw;
    logic [3:0]  thr;
    logic [2:0]  n_broken;
    logic        fire;
    logic        active;
    logic [15:0] lfsr_next;

    assign ch        = lfsr_q[1:0];
    assign roll      = lfsr_q[7:4];
    assign hexraw    = lfsr_q[11:8];
    assign n_broken  = 3'(broken[0]) + 3'(broken[1]) + 3'(broken[2]) + 3'(broken[3]);
    assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
    assign active    = (state_q == ARMED) || (state_q == ISSUE);

    // Break probability threshold grows with level.
    always_comb begin
        thr = 4'd2;
        case (level_q)
            2'd0:    thr = 4'd2;
            2'd1:    thr = 4'd5;
            2'd2:    thr = 4'd8;
            default: thr = 4'd11;
        endcase
    end

    assign fire = (roll <= thr) && !broken[ch] && (cool_q[ch] == 8'd0) && (n_broken < MAX_BROKEN);

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        break_req_d  = break_req_q;
        random_hex_d = random_hex_q;
        level_d      = level_q;
        missed_d     = 1'b0;
        cool_d       = cool_q;
        tick_cnt_d   = tick_cnt_q;
        ack_cnt_d    = ack_cnt_q;
        ch_d         = ch_q;

        if (!active || gameover_ctrl) begin
            // IDLE, game over and illegal encodings all land here with a full clear.
            lfsr_d       = SEED;
            break_req_d  = 4'd0;
            random_hex_d = 4'd0;
            level_d      = 2'd0;
            cool_d       = '0;
            tick_cnt_d   = 8'd0;
            ack_cnt_d    = 8'd0;
            ch_d         = 2'd0;
            state_d      = (state_q == IDLE && play_flag) ? ARMED : IDLE;
        end else begin
            lfsr_d = lfsr_next;

            // Cooldown only runs once the part is repaired.
            for (int i = 0; i < N_PARTS; i++) begin
                if (cool_q[i] != 8'd0 && !broken[i]) begin
                    cool_d[i] = cool_q[i] - 8'd1;
                end
            end

            if (tick_cnt_q == LVL_LAST) begin
                tick_cnt_d = 8'd0;
                if (level_q != 2'd3) begin
                    level_d = level_q + 2'd1;
                end
            end else begin
                tick_cnt_d = tick_cnt_q + 8'd1;
            end

            case (state_q)
                ARMED: begin
                    if (fire) begin
                        break_req_d  = 4'(4'b0001 << ch);
                        random_hex_d = (hexraw == 4'd0) ? 4'hF : hexraw;
                        ch_d         = ch;
                        ack_cnt_d    = 8'd0;
                        state_d      = ISSUE;
                    end
                end
                ISSUE: begin
                    if (broken[ch_q]) begin
                        break_req_d    = 4'd0;
                        cool_d[ch_q]   = COOLDOWN;
                        state_d        = ARMED;
                    end else if (ack_cnt_q == ACK_LAST) begin
                        break_req_d = 4'd0;
                        missed_d    = 1'b1;
                        state_d     = ARMED;
                    end else begin
                        ack_cnt_d = ack_cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge timer_clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            lfsr_q       <= SEED;
            break_req_q  <= 4'd0;
            random_hex_q <= 4'd0;
            level_q      <= 2'd0;
            missed_q     <= 1'b0;
            cool_q       <= '0;
            tick_cnt_q   <= 8'd0;
            ack_cnt_q    <= 8'd0;
            ch_q         <= 2'd0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            break_req_q  <= break_req_d;
            random_hex_q <= random_hex_d;
            level_q      <= level_d;
            missed_q     <= missed_d;
            cool_q       <= cool_d;
            tick_cnt_q   <= tick_cnt_d;
            ack_cnt_q    <= ack_cnt_d;
            ch_q         <= ch_d;
        end
    end

    assign break_req  = break_req_q;
    assign random_hex = random_hex_q;
    assign level      = level_q;
    assign missed     = missed_q;

endmodule
